serial_alu_engine: RTL and testbench

//  Parametrised sequential ALU. Operands A and B are loaded one bit at a time through a serial shift-in port.

---
 rtl/serial_alu_engine_if.sv | 42 ++++
 rtl/serial_alu_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_serial_alu_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_engine_if.sv
// -----------------------------------------------------------------------------
// serial_alu_engine_if
//   Bundles the serial operand load port, the operation request handshake and
//   the registered result/flag outputs of serial_alu_engine.
//   master : drives bit_in/sel/load/op/start, observes busy/done/result/flags
//   slave  : the engine side
// Signals
//   bit_in    serial operand bit (MSB first)
//   sel       load target: 0 = A, 1 = B
//   load      shift bit_in into the selected operand this cycle
//   op        operation code
//   start     request an operation on the current A/B/op
//   busy      high while the engine is not idle
//   done      one-cycle pulse when result/flags update
//   result    result (low half for MUL)
//   result_hi MUL high half, zero for every other op
//   flags     {V,C,N,Z}
// -----------------------------------------------------------------------------
interface serial_alu_engine_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             sel;
    logic             load;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output bit_in, sel, load, op, start,
        input  busy, done, result, result_hi, flags
    );

    modport slave (
        input  bit_in, sel, load, op, start,
        output busy, done, result, result_hi, flags
    );
endinterface

// File: rtl/serial_alu_engine.sv
// -----------------------------------------------------------------------------
// serial_alu_engine
//   Sequential ALU with serially loaded operands. ADD/SUB/AND/OR/XOR finish in
//   one execute cycle, SHL/SHR shift one bit per cycle, MUL is a WIDTH-cycle
//   unsigned shift-add. Result and flags are registered and held until the
//   next operation completes.
// Ports
//   clk    clock, all state on the rising edge
//   reset  asynchronous, active-high reset
//   bus    serial_alu_engine_if slave modport (load port, handshake, results)
// -----------------------------------------------------------------------------
module serial_alu_engine #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_alu_engine_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] wa_r;      // working A / shift register
    logic [WIDTH-1:0] wb_r;      // working B / MUL low product half
    logic [WIDTH-1:0] mhi_r;     // MUL high product half
    logic [SW-1:0]    cnt_r;     // remaining shift steps / MUL steps - 1
    logic             carry_r;   // last bit shifted out
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    logic [3:0]       flags_r;
    logic             busy_r;
    logic             done_r;

    logic             last_s;
    logic [WIDTH-1:0] wa_nxt_s;
    logic [WIDTH-1:0] wb_nxt_s;
    logic [WIDTH-1:0] mhi_nxt_s;
    logic [SW-1:0]    cnt_nxt_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] res_hi_s;
    logic             flag_c_s;
    logic             flag_v_s;
    logic             flag_z_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   macc_s;

    // Execute-cycle datapath: next working values, candidate result and flags.
    always_comb begin
        last_s      = 1'b0;
        wa_nxt_s    = wa_r;
        wb_nxt_s    = wb_r;
        mhi_nxt_s   = mhi_r;
        cnt_nxt_s   = cnt_r;
        carry_nxt_s = carry_r;
        res_s       = result_r;
        res_hi_s    = {WIDTH{1'b0}};
        flag_c_s    = 1'b0;
        flag_v_s    = 1'b0;
        flag_z_s    = 1'b0;
        sum_s       = {1'b0, wa_r} + {1'b0, wb_r};
        diff_s      = {1'b0, wa_r} - {1'b0, wb_r};
        // MUL step: add A into the high half when the current multiplier bit is set
        if (wb_r[0]) begin
            macc_s = {1'b0, mhi_r} + {1'b0, wa_r};
        end else begin
            macc_s = {1'b0, mhi_r};
        end

        case (op_r)
            OP_ADD: begin
                last_s   = 1'b1;
                res_s    = sum_s[M:0];
                flag_c_s = sum_s[WIDTH];
                flag_v_s = (wa_r[M] == wb_r[M]) && (sum_s[M] != wa_r[M]);
            end
            OP_SUB: begin
                last_s   = 1'b1;
                res_s    = diff_s[M:0];
                flag_c_s = diff_s[WIDTH];
                flag_v_s = (wa_r[M] != wb_r[M]) && (diff_s[M] != wa_r[M]);
            end
            OP_AND: begin
                last_s = 1'b1;
                res_s  = wa_r & wb_r;
            end
            OP_OR: begin
                last_s = 1'b1;
                res_s  = wa_r | wb_r;
            end
            OP_XOR: begin
                last_s = 1'b1;
                res_s  = wa_r ^ wb_r;
            end
            OP_SHL: begin
                // a zero shift amount still takes one cycle and passes A through
                if (cnt_r != {SW{1'b0}}) begin
                    wa_nxt_s    = {wa_r[M-1:0], 1'b0};
                    carry_nxt_s = wa_r[M];
                    cnt_nxt_s   = cnt_r - SW'(1);
                end else begin
                    wa_nxt_s    = wa_r;
                    carry_nxt_s = carry_r;
                    cnt_nxt_s   = cnt_r;
                end
                last_s   = (cnt_r <= SW'(1));
                res_s    = wa_nxt_s;
                flag_c_s = carry_nxt_s;
            end
            OP_SHR: begin
                if (cnt_r != {SW{1'b0}}) begin
                    wa_nxt_s    = {1'b0, wa_r[M:1]};
                    carry_nxt_s = wa_r[0];
                    cnt_nxt_s   = cnt_r - SW'(1);
                end else begin
                    wa_nxt_s    = wa_r;
                    carry_nxt_s = carry_r;
                    cnt_nxt_s   = cnt_r;
                end
                last_s   = (cnt_r <= SW'(1));
                res_s    = wa_nxt_s;
                flag_c_s = carry_nxt_s;
            end
            OP_MUL: begin
                // {mhi, wb} shifts right one place per cycle, absorbing the sum carry
                mhi_nxt_s = macc_s[WIDTH:1];
                wb_nxt_s  = {macc_s[0], wb_r[M:1]};
                cnt_nxt_s = cnt_r - SW'(1);
                last_s    = (cnt_r == {SW{1'b0}});
                res_s     = wb_nxt_s;
                res_hi_s  = mhi_nxt_s;
                flag_c_s  = (mhi_nxt_s != {WIDTH{1'b0}});
            end
            default: begin
                last_s = 1'b1;
                res_s  = {WIDTH{1'b0}};
            end
        endcase

        // MUL zero flag covers the full double-width product
        if (op_r == OP_MUL) begin
            flag_z_s = ({mhi_nxt_s, wb_nxt_s} == {(2*WIDTH){1'b0}});
        end else begin
            flag_z_s = (res_s == {WIDTH{1'b0}});
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Serial operand shift-in, only while idle and not starting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && bus.load && !bus.start) begin
            if (bus.sel) begin
                b_r <= {b_r[M-1:0], bus.bit_in};
            end else begin
                a_r <= {a_r[M-1:0], bus.bit_in};
            end
        end
    end

    // Working registers: captured on start, stepped during EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= 3'd0;
            wa_r    <= {WIDTH{1'b0}};
            wb_r    <= {WIDTH{1'b0}};
            mhi_r   <= {WIDTH{1'b0}};
            cnt_r   <= {SW{1'b0}};
            carry_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            op_r    <= bus.op;
            wa_r    <= a_r;
            wb_r    <= b_r;
            mhi_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            if (bus.op == OP_MUL) begin
                cnt_r <= SW'(WIDTH - 1);
            end else begin
                cnt_r <= b_r[SW-1:0];
            end
        end else if (state_r == ST_EXEC) begin
            wa_r    <= wa_nxt_s;
            wb_r    <= wb_nxt_s;
            mhi_r   <= mhi_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    // Result/flag registers, written only on the completing EXEC edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 4'd0;
        end else if ((state_r == ST_EXEC) && last_s) begin
            result_r    <= res_s;
            result_hi_r <= res_hi_s;
            flags_r     <= {flag_v_s, flag_c_s, res_s[M], flag_z_s};
        end
    end

    // Registered handshake outputs derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.flags     = flags_r;

endmodule

// File: tb/tb_serial_alu_engine.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_engine
//   Directed bench for serial_alu_engine at WIDTH=8 and WIDTH=16. Expected
//   results come from an arithmetic reference model, are queued when an
//   operation starts and are popped when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_alu_engine;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  flags;
        int          n;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    serial_alu_engine_if #(.WIDTH(8))  ifc8();
    serial_alu_engine_if #(.WIDTH(16)) ifc16();

    serial_alu_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(ifc8));
    serial_alu_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(ifc16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] mask, aa, bb, r, hi, p;
        int          sh;
        logic        c, v, am, bm, rm, z;
        mask = (32'd1 << w) - 32'd1;
        aa   = {16'd0, a} & mask;
        bb   = {16'd0, b} & mask;
        sh   = int'(bb) % w;
        hi   = 32'd0;
        p    = 32'd0;
        c    = 1'b0;
        v    = 1'b0;
        e.n  = 1;
        am   = aa[w-1];
        bm   = bb[w-1];
        case (op)
            3'd0: begin p = aa + bb; r = p & mask; c = p[w]; end
            3'd1: begin r = (aa - bb) & mask; c = (aa < bb); end
            3'd2: r = aa & bb;
            3'd3: r = aa | bb;
            3'd4: r = aa ^ bb;
            3'd5: begin
                r   = (aa << sh) & mask;
                c   = (sh != 0) ? aa[w-sh] : 1'b0;
                e.n = (sh == 0) ? 1 : sh;
            end
            3'd6: begin
                r   = aa >> sh;
                c   = (sh != 0) ? aa[sh-1] : 1'b0;
                e.n = (sh == 0) ? 1 : sh;
            end
            default: begin
                p   = aa * bb;
                r   = p & mask;
                hi  = p >> w;
                c   = (hi != 32'd0);
                e.n = w;
            end
        endcase
        rm = r[w-1];
        if (op == 3'd0) v = (am == bm) && (rm != am);
        if (op == 3'd1) v = (am != bm) && (rm != am);
        z = (op == 3'd7) ? (p == 32'd0) : (r == 32'd0);
        e.res   = r[15:0];
        e.hi    = hi[15:0];
        e.flags = {v, c, rm, z};
        return e;
    endfunction

    task automatic drive(input int w, input logic ld, input logic sl,
                         input logic bi, input logic st, input logic [2:0] o);
        if (w == 16) begin
            ifc16.load = ld; ifc16.sel = sl; ifc16.bit_in = bi; ifc16.start = st; ifc16.op = o;
        end else begin
            ifc8.load = ld; ifc8.sel = sl; ifc8.bit_in = bi; ifc8.start = st; ifc8.op = o;
        end
    endtask

    task automatic sample(input int w, output logic d, output logic bz,
                          output logic [15:0] r, output logic [15:0] rh, output logic [3:0] f);
        if (w == 16) begin
            d = ifc16.done; bz = ifc16.busy; r = ifc16.result; rh = ifc16.result_hi; f = ifc16.flags;
        end else begin
            d = ifc8.done; bz = ifc8.busy; r = {8'd0, ifc8.result}; rh = {8'd0, ifc8.result_hi}; f = ifc8.flags;
        end
    endtask

    // Shift one operand in MSB first; called and returns on a falling edge.
    task automatic load_op(input int w, input logic sl, input logic [15:0] val);
        logic [15:0] v;
        v = val;
        for (int i = w - 1; i >= 0; i--) begin
            drive(w, 1'b1, sl, v[i], 1'b0, 3'd0);
            @(negedge clk);
        end
        drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic load_ab(input int w, input logic [15:0] a, input logic [15:0] b);
        load_op(w, 1'b0, a);
        load_op(w, 1'b1, b);
    endtask

    // Start an op, wait for done, compare against the scoreboard head.
    task automatic run_op(input int w, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input bit disturb, input string tag);
        exp_t        e;
        int          lat;
        int          bcnt;
        logic        d, bz;
        logic [15:0] r, rh;
        logic [3:0]  f;
        sb.push_back(model(w, op, a, b));
        drive(w, 1'b0, 1'b0, 1'b0, 1'b1, op);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 1'b0, 1'b0, op);
        lat  = 1;
        bcnt = 0;
        sample(w, d, bz, r, rh, f);
        if (bz) bcnt++;
        while (!d && lat < 100) begin
            if (disturb && lat >= 2 && lat <= 3) drive(w, 1'b1, 1'b0, 1'b1, 1'b1, op);
            else drive(w, 1'b0, 1'b0, 1'b0, 1'b0, op);
            @(negedge clk);
            lat++;
            sample(w, d, bz, r, rh, f);
            if (bz) bcnt++;
        end
        drive(w, 1'b0, 1'b0, 1'b0, 1'b0, op);
        e = sb.pop_front();
        chk({tag, "_done_seen"}, {31'd0, d}, 32'd1);
        chk({tag, "_result"}, {16'd0, r}, {16'd0, e.res});
        chk({tag, "_result_hi"}, {16'd0, rh}, {16'd0, e.hi});
        chk({tag, "_flags"}, {28'd0, f}, {28'd0, e.flags});
        chk({tag, "_latency"}, lat, e.n + 1);
        chk({tag, "_busy_cycles"}, bcnt, e.n + 1);
        @(negedge clk);
        sample(w, d, bz, r, rh, f);
        chk({tag, "_idle_busy"}, {31'd0, bz}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, d}, 32'd0);
        chk({tag, "_hold_result"}, {16'd0, r}, {16'd0, e.res});
    endtask

    initial begin
        logic        d, bz;
        logic [15:0] r, rh;
        logic [3:0]  f;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(16, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        sample(8, d, bz, r, rh, f);
        chk("rst_busy", {31'd0, bz}, 32'd0);
        chk("rst_done", {31'd0, d}, 32'd0);
        chk("rst_result", {16'd0, r}, 32'd0);
        chk("rst_flags", {28'd0, f}, 32'd0);

        load_ab(8, 16'h7F, 16'h01); run_op(8, 3'd0, 16'h7F, 16'h01, 1'b0, "add_ovf");
        load_ab(8, 16'h05, 16'h07); run_op(8, 3'd1, 16'h05, 16'h07, 1'b0, "sub_borrow");
        load_ab(8, 16'h33, 16'h33); run_op(8, 3'd1, 16'h33, 16'h33, 1'b0, "sub_zero");
        load_ab(8, 16'hC6, 16'h5A); run_op(8, 3'd2, 16'hC6, 16'h5A, 1'b0, "and");
        run_op(8, 3'd3, 16'hC6, 16'h5A, 1'b0, "or");
        run_op(8, 3'd4, 16'hC6, 16'h5A, 1'b0, "xor");
        load_ab(8, 16'h81, 16'h03); run_op(8, 3'd5, 16'h81, 16'h03, 1'b0, "shl3");
        load_ab(8, 16'h81, 16'h00); run_op(8, 3'd5, 16'h81, 16'h00, 1'b0, "shl0");
        load_ab(8, 16'hB5, 16'h05); run_op(8, 3'd6, 16'hB5, 16'h05, 1'b0, "shr5");
        load_ab(8, 16'hFF, 16'hFF); run_op(8, 3'd7, 16'hFF, 16'hFF, 1'b0, "mul_ff");
        load_ab(8, 16'h00, 16'hFF); run_op(8, 3'd7, 16'h00, 16'hFF, 1'b0, "mul_zero");

        // load/start pulsed mid-MUL must not touch A, B or queue another op
        load_ab(8, 16'h9D, 16'h37); run_op(8, 3'd7, 16'h9D, 16'h37, 1'b1, "mul_disturb");
        run_op(8, 3'd0, 16'h9D, 16'h37, 1'b0, "ab_kept");

        // reset in the middle of a MUL
        drive(8, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sample(8, d, bz, r, rh, f);
        chk("midrst_busy", {31'd0, bz}, 32'd0);
        chk("midrst_done", {31'd0, d}, 32'd0);
        chk("midrst_result", {16'd0, r}, 32'd0);
        chk("midrst_result_hi", {16'd0, rh}, 32'd0);
        chk("midrst_flags", {28'd0, f}, 32'd0);
        run_op(8, 3'd0, 16'h00, 16'h00, 1'b0, "midrst_ab_cleared");

        // WIDTH=16 boundaries
        load_ab(16, 16'hFFFF, 16'h0001); run_op(16, 3'd0, 16'hFFFF, 16'h0001, 1'b0, "w16_add_wrap");
        load_ab(16, 16'h8000, 16'h000F); run_op(16, 3'd6, 16'h8000, 16'h000F, 1'b0, "w16_shr15");
        load_ab(16, 16'hABCD, 16'h1234); run_op(16, 3'd7, 16'hABCD, 16'h1234, 1'b0, "w16_mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
